// File: rtl/nth_prime_gen.sv
`default_nettype none
// ============================================================================
// Module   : nth_prime_gen
// Brief    : Returns the n-th prime (0-based) below 512 by trial division,
//            one divisor test per clock, with a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module nth_prime_gen #(
    parameter int MAX_INDEX = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] index,
    output logic       busy,
    output logic       done,
    output logic [8:0] prime,
    output logic       error
);

    localparam logic [6:0] c_max_index = 7'(MAX_INDEX);
    localparam logic [8:0] c_first_cand = 9'd2;
    localparam logic [4:0] c_first_div  = 5'd2;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } state_t;

    state_t     r_state,    w_state_nxt;
    logic [6:0] r_target,   w_target_nxt;
    logic [8:0] r_cand,     w_cand_nxt;
    logic [6:0] r_count,    w_count_nxt;
    logic [4:0] r_d,        w_d_nxt;
    logic       r_err_pend, w_err_pend_nxt;
    logic       r_busy,     w_busy_nxt;
    logic       r_done,     w_done_nxt;
    logic [8:0] r_prime,    w_prime_nxt;
    logic       r_error,    w_error_nxt;

    logic [9:0] w_d_sq;
    logic       w_past_root;
    logic [8:0] w_divisor;
    logic [8:0] w_rem;
    logic       w_divides;

    // Divisor is forced nonzero so the remainder is defined even while idle.
    assign w_d_sq      = {5'd0, r_d} * {5'd0, r_d};
    assign w_past_root = (w_d_sq > {1'b0, r_cand});
    assign w_divisor   = (r_d == 5'd0) ? 9'd1 : {4'd0, r_d};
    assign w_rem       = r_cand % w_divisor;
    assign w_divides   = (w_rem == 9'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_target   <= 7'd0;
            r_cand     <= 9'd0;
            r_count    <= 7'd0;
            r_d        <= 5'd0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_prime    <= 9'd0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_cand     <= w_cand_nxt;
            r_count    <= w_count_nxt;
            r_d        <= w_d_nxt;
            r_err_pend <= w_err_pend_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_prime    <= w_prime_nxt;
            r_error    <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_cand_nxt     = r_cand;
        w_count_nxt    = r_count;
        w_d_nxt        = r_d;
        w_err_pend_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_prime_nxt    = r_prime;
        w_error_nxt    = r_error;

        case (r_state)
            S_IDLE: begin
                // A rejected index reports one edge after acceptance.
                if (r_err_pend) begin
                    w_done_nxt  = 1'b1;
                    w_error_nxt = 1'b1;
                    w_prime_nxt = 9'd0;
                end else if (start) begin
                    if (index > c_max_index) begin
                        w_err_pend_nxt = 1'b1;
                    end else begin
                        w_target_nxt = index;
                        w_cand_nxt   = c_first_cand;
                        w_count_nxt  = 7'd0;
                        w_d_nxt      = c_first_div;
                        w_state_nxt  = S_SEARCH;
                    end
                end
            end
            S_SEARCH: begin
                if (w_past_root) begin
                    if (r_count == r_target) begin
                        w_prime_nxt = r_cand;
                        w_error_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count + 7'd1;
                        w_cand_nxt  = r_cand + 9'd1;
                        w_d_nxt     = c_first_div;
                    end
                end else if (w_divides) begin
                    w_cand_nxt = r_cand + 9'd1;
                    w_d_nxt    = c_first_div;
                end else begin
                    w_d_nxt = r_d + 5'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt == S_SEARCH);
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign prime = r_prime;
    assign error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_nth_prime_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_nth_prime_gen
// Brief    : Directed self-checking bench for nth_prime_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nth_prime_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] index;
    logic       busy;
    logic       done;
    logic [8:0] prime;
    logic       error;

    int total = 0;
    int bad   = 0;

    int spf [0:511];
    int nth [0:96];

    nth_prime_gen #(.MAX_INDEX(96)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .index (index),
        .busy  (busy),
        .done  (done),
        .prime (prime),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int is_prime(input int v);
        if (v < 2) return 0;
        for (int k = 2; k * k <= v; k++) if (v % k == 0) return 0;
        return 1;
    endfunction

    // Cycle cost: primes pay floor(sqrt) cycles, composites pay spf-1 cycles.
    function automatic int exp_cycles(input int idx);
        int t = 0;
        for (int c = 2; c <= nth[idx]; c++)
            t += (spf[c] == c) ? isqrt(c) : (spf[c] - 1);
        return t;
    endfunction

    task automatic build_tables();
        int n = 0;
        for (int v = 0; v < 512; v++) spf[v] = 0;
        for (int v = 2; v < 512; v++) begin
            if (spf[v] == 0) begin
                for (int m = v; m < 512; m += v) if (spf[m] == 0) spf[m] = v;
                if (n <= 96) nth[n] = v;
                n++;
            end
        end
    endtask

    task automatic run_req(input int idx, input int limit, output int cyc,
                           output int p, output int e, output int busy_seen,
                           output int busy_at_done, output int done_after);
        @(negedge clk);
        start = 1'b1;
        index = 7'(idx);
        @(posedge clk);
        #1;
        start = 1'b0;
        index = 7'($urandom_range(0, 127));
        cyc = -1; p = -1; e = -1; busy_seen = 0; busy_at_done = -1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = c; p = int'(prime); e = int'(error);
                busy_at_done = int'(busy);
                break;
            end
            if (busy) busy_seen = 1;
        end
        @(posedge clk);
        #1;
        done_after = int'(done);
    endtask

    initial begin
        int cyc, p, e, bs, bd, da, prev, first, ndone, pcap;

        build_tables();
        rst_n = 1'b0;
        start = 1'b0;
        index = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",  int'(busy),  0);
        chk("reset_done",  int'(done),  0);
        chk("reset_prime", int'(prime), 0);
        chk("reset_error", int'(error), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(0, 100, cyc, p, e, bs, bd, da);
        chk("idx0_prime", p, 2);
        chk("idx0_T", cyc, 1);
        chk("idx0_error", e, 0);
        chk("idx0_busy_at_done", bd, 0);
        chk("idx0_single_done", da, 0);

        run_req(1, 100, cyc, p, e, bs, bd, da);
        chk("idx1_prime", p, 3);
        chk("idx1_T", cyc, 2);

        run_req(2, 100, cyc, p, e, bs, bd, da);
        chk("idx2_prime", p, 5);
        chk("idx2_T", cyc, 5);
        chk("idx2_busy_seen", bs, 1);

        run_req(10, 1000, cyc, p, e, bs, bd, da);
        chk("idx10_prime", p, 31);
        chk("idx10_isprime", is_prime(p), 1);
        run_req(14, 1000, cyc, p, e, bs, bd, da);
        chk("idx14_prime", p, 47);
        chk("idx14_isprime", is_prime(p), 1);
        run_req(24, 2000, cyc, p, e, bs, bd, da);
        chk("idx24_prime", p, 97);
        chk("idx24_isprime", is_prime(p), 1);

        run_req(96, 10000, cyc, p, e, bs, bd, da);
        chk("idx96_prime", p, 509);
        chk("idx96_T", cyc, exp_cycles(96));
        chk("idx96_error", e, 0);

        run_req(97, 20, cyc, p, e, bs, bd, da);
        chk("idx97_T", cyc, 1);
        chk("idx97_error", e, 1);
        chk("idx97_prime", p, 0);
        chk("idx97_busy_seen", bs, 0);
        chk("idx97_busy_at_done", bd, 0);
        chk("idx97_single_done", da, 0);
        run_req(127, 20, cyc, p, e, bs, bd, da);
        chk("idx127_error", e, 1);
        chk("idx127_prime", p, 0);
        chk("idx127_busy_seen", bs, 0);
        run_req(1, 100, cyc, p, e, bs, bd, da);
        chk("after_err_prime", p, 3);
        chk("after_err_error", e, 0);

        // Second start while busy must not disturb the running search.
        @(negedge clk);
        start = 1'b1;
        index = 7'd96;
        @(posedge clk);
        #1;
        start = 1'b0;
        first = -1; ndone = 0; pcap = -1;
        for (int c = 1; c <= 10000; c++) begin
            @(posedge clk);
            #1;
            if (c == 20) begin start = 1'b1; index = 7'd0; end
            if (c == 21) start = 1'b0;
            if (done) begin
                ndone++;
                pcap = int'(prime);
                if (first == -1) first = c;
            end
            if (first != -1 && c >= first + 6) break;
        end
        chk("ignore_prime", pcap, 509);
        chk("ignore_T", first, exp_cycles(96));
        chk("ignore_done_count", ndone, 1);

        prev = 0;
        for (int i = 0; i <= 96; i += ((i < 40) ? 1 : 7)) begin
            run_req(i, 10000, cyc, p, e, bs, bd, da);
            chk($sformatf("sweep%0d_prime", i), p, nth[i]);
            chk($sformatf("sweep%0d_T", i), cyc, exp_cycles(i));
            chk($sformatf("sweep%0d_incr", i), int'(p > prev), 1);
            prev = p;
        end

        // Asynchronous reset in the middle of a search.
        @(negedge clk);
        start = 1'b1;
        index = 7'd50;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_prime", int'(prime), 0);
        chk("rst_error", int'(error), 0);
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        run_req(3, 100, cyc, p, e, bs, bd, da);
        chk("post_rst_prime", p, 7);
        chk("post_rst_T", cyc, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
